// File: rtl/trsq_pkg.sv
// trsq_pkg: shared types and constants for the TRSQ8 program sequencer.
// Holds the per-cycle action encoding, default vector layout and clog2.
package trsq_pkg;

   typedef enum logic [2:0] {
      ACT_IRQ,
      ACT_HALT,
      ACT_JUMP,
      ACT_CALL,
      ACT_RET,
      ACT_SKIP,
      ACT_INC
   } act_e;

   localparam int TRSQ_VEC_BASE   = 4;
   localparam int TRSQ_VEC_STRIDE = 4;

   function automatic int trsq_clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/trsq_irq_arb.sv
// trsq_irq_arb: irq edge detect, pending bits, mask and priority pick.
// TRSQ_IRQ_SYNC_EN adds a 2-flop synchroniser ahead of edge detection.
module trsq_irq_arb
   import trsq_pkg::*;
#(
   parameter int IRQ_N = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IRQ_N-1:0] irq,
   input  logic [IRQ_N-1:0] mask,
   input  logic             en,
   output logic             eligible,
   output logic [2:0]       index,
   output logic [IRQ_N-1:0] ack
);

   logic [IRQ_N-1:0] irq_s;
   logic [IRQ_N-1:0] irq_d;
   logic [IRQ_N-1:0] pend;
   logic [IRQ_N-1:0] rise;
   logic [IRQ_N-1:0] req;
   logic [IRQ_N-1:0] sel;

`ifdef TRSQ_IRQ_SYNC_EN
   logic [IRQ_N-1:0] sync1;
   logic [IRQ_N-1:0] sync2;

   // Two-flop synchroniser for asynchronous request pins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= irq;
         sync2 <= sync1;
      end
   end

   assign irq_s = sync2;
`else
   assign irq_s = irq;
`endif

   assign rise     = irq_s & ~irq_d;
   assign req      = pend & mask;
   assign eligible = en & (|req);

   // Lowest enabled pending channel wins
   always_comb begin
      index = '0;
      for (int i = IRQ_N - 1; i >= 0; i--)
         if (req[i]) index = 3'(i);
      sel = eligible ? (IRQ_N'(1) << index) : '0;
   end

   // A new edge beats a same-cycle ack so the channel is not lost
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_d <= '0;
         pend  <= '0;
         ack   <= '0;
      end else begin
         irq_d <= irq_s;
         pend  <= (pend & ~sel) | rise;
         ack   <= sel;
      end
   end

endmodule

// File: rtl/trsq_seq.sv
// trsq_seq: TRSQ8 program sequencer (PC, return stack, irq entry).
// Define TRSQ_IRQ_SYNC_EN to synchronise irq_ip inside trsq_irq_arb.
module trsq_seq
   import trsq_pkg::*;
#(
   parameter  int PC_W        = 13,
   parameter  int STACK_DEPTH = 4,
   parameter  int IRQ_N       = 4,
   parameter  int VEC_BASE    = TRSQ_VEC_BASE,
   parameter  int VEC_STRIDE  = TRSQ_VEC_STRIDE,
   localparam int DW          = trsq_clog2(STACK_DEPTH + 1)
) (
   input  logic             clk_ip,
   input  logic             reset_n_ip,
   output logic [PC_W-1:0]  prom_addr_op,
   input  logic             jump_ip,
   input  logic             call_ip,
   input  logic [PC_W-1:0]  jump_addr_ip,
   input  logic             ret_ip,
   input  logic             reti_ip,
   input  logic             skip_ip,
   input  logic             halt_ip,
   input  logic [IRQ_N-1:0] irq_ip,
   input  logic [IRQ_N-1:0] irq_mask_ip,
   input  logic             gie_ip,
   output logic [IRQ_N-1:0] irq_ack_op,
   output logic             squash_op,
   output logic             in_isr_op,
   output logic [DW-1:0]    depth_op,
   output logic             stack_ovf_op,
   output logic             stack_unf_op
);

   localparam int AW = (STACK_DEPTH > 1) ? trsq_clog2(STACK_DEPTH) : 1;

   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] pc_skip;
   logic [PC_W-1:0] vec;
   logic [PC_W-1:0] push_val;
   logic [PC_W-1:0] stk [STACK_DEPTH];
   logic [DW-1:0]   ptr;
   logic [AW-1:0]   wr_idx;
   logic [AW-1:0]   rd_idx;
   logic            full;
   logic            empty;
   logic            in_isr;
   logic            ovf;
   logic            unf;
   logic            elig;
   logic [2:0]      idx;
   act_e            act;

   trsq_irq_arb #(.IRQ_N(IRQ_N)) u_arb (
      .clk      (clk_ip),
      .rst_n    (reset_n_ip),
      .irq      (irq_ip),
      .mask     (irq_mask_ip),
      .en       (gie_ip & ~in_isr),
      .eligible (elig),
      .index    (idx),
      .ack      (irq_ack_op)
   );

   assign pc_inc   = pc + PC_W'(1);
   assign pc_skip  = pc + PC_W'(2);
   assign vec      = PC_W'(VEC_BASE) + PC_W'(VEC_STRIDE) * PC_W'(idx);
   assign full     = (ptr == DW'(STACK_DEPTH));
   assign empty    = (ptr == '0);
   assign wr_idx   = AW'(ptr);
   assign rd_idx   = AW'(ptr - DW'(1));
   assign push_val = (act == ACT_IRQ && !halt_ip) ? pc : pc_inc;

   // Pick this cycle's single action in priority order
   always_comb begin
      if (elig)                   act = ACT_IRQ;
      else if (halt_ip)           act = ACT_HALT;
      else if (jump_ip)           act = ACT_JUMP;
      else if (call_ip)           act = ACT_CALL;
      else if (ret_ip || reti_ip) act = ACT_RET;
      else if (skip_ip)           act = ACT_SKIP;
      else                        act = ACT_INC;
   end

   // PC, return stack and status flags
   always_ff @(posedge clk_ip or negedge reset_n_ip) begin
      if (!reset_n_ip) begin
         pc     <= '0;
         ptr    <= '0;
         in_isr <= 1'b0;
         ovf    <= 1'b0;
         unf    <= 1'b0;
         for (int i = 0; i < STACK_DEPTH; i++)
            stk[i] <= '0;
      end else begin
         case (act)
            ACT_IRQ, ACT_CALL: begin
               pc <= (act == ACT_IRQ) ? vec : jump_addr_ip;
               if (act == ACT_IRQ) in_isr <= 1'b1;
               if (full) begin
                  ovf <= 1'b1;
               end else begin
                  stk[wr_idx] <= push_val;
                  ptr         <= ptr + DW'(1);
               end
            end
            ACT_HALT: pc <= pc;
            ACT_JUMP: pc <= jump_addr_ip;
            ACT_RET: begin
               if (reti_ip) in_isr <= 1'b0;
               if (empty) begin
                  unf <= 1'b1;
                  pc  <= pc_inc;
               end else begin
                  pc  <= stk[rd_idx];
                  ptr <= ptr - DW'(1);
               end
            end
            ACT_SKIP: pc <= pc_skip;
            default:  pc <= pc_inc;
         endcase
      end
   end

   assign prom_addr_op = pc;
   assign squash_op    = (act == ACT_IRQ);
   assign in_isr_op    = in_isr;
   assign depth_op     = ptr;
   assign stack_ovf_op = ovf;
   assign stack_unf_op = unf;

endmodule

// File: tb/tb_trsq_seq.sv
// tb_trsq_seq: directed and randomized checks of trsq_seq.
// Expected values come from constants and a queue-based PC/stack model.
module tb_trsq_seq;

   localparam int PC_W = 13;
   localparam int SD   = 4;
   localparam int IN   = 4;
   localparam int MODV = 1 << PC_W;
`ifdef TRSQ_IRQ_SYNC_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic [PC_W-1:0] pc;
   logic            jump, call, ret, reti, skip, halt, gie;
   logic [PC_W-1:0] addr;
   logic [IN-1:0]   irq, mask, ack;
   logic            squash, in_isr, ovf, unf;
   logic [2:0]      depth;

   int n_checks = 0;
   int n_err    = 0;
   int mq[$];

   trsq_seq #(.PC_W(PC_W), .STACK_DEPTH(SD), .IRQ_N(IN)) dut (
      .clk_ip       (clk),
      .reset_n_ip   (rst_n),
      .prom_addr_op (pc),
      .jump_ip      (jump),
      .call_ip      (call),
      .jump_addr_ip (addr),
      .ret_ip       (ret),
      .reti_ip      (reti),
      .skip_ip      (skip),
      .halt_ip      (halt),
      .irq_ip       (irq),
      .irq_mask_ip  (mask),
      .gie_ip       (gie),
      .irq_ack_op   (ack),
      .squash_op    (squash),
      .in_isr_op    (in_isr),
      .depth_op     (depth),
      .stack_ovf_op (ovf),
      .stack_unf_op (unf)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      jump = 0; call = 0; ret = 0; reti = 0; skip = 0; halt = 0;
      gie = 0; addr = '0; irq = '0; mask = '0;
   endtask

   task automatic do_reset();
      clear_in();
      rst_n = 0;
      tick();
      rst_n = 1;
   endtask

   task automatic test_reset();
      clear_in();
      #2 rst_n = 0;
      #2;
      n_checks++; if (pc !== 0) begin n_err++; $display("FAIL rst_pc act=%0h req=0", pc); end
      n_checks++; if (depth !== 0) begin n_err++; $display("FAIL rst_depth act=%0d req=0", depth); end
      n_checks++; if ({ovf, unf, in_isr, squash} !== 4'b0) begin n_err++; $display("FAIL rst_flags act=%b req=0000", {ovf, unf, in_isr, squash}); end
      tick();
      n_checks++; if (ack !== 0) begin n_err++; $display("FAIL rst_ack act=%b req=0", ack); end
      n_checks++; if (pc !== 0) begin n_err++; $display("FAIL rst_hold act=%0h req=0", pc); end
      rst_n = 1;
   endtask

   task automatic test_sequence();
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         tick();
         n_checks++; if (pc !== PC_W'(i)) begin n_err++; $display("FAIL seq_pc act=%0h req=%0h", pc, i); end
      end
      skip = 1; tick(); skip = 0;
      n_checks++; if (pc !== 7) begin n_err++; $display("FAIL skip act=%0h req=7", pc); end
      tick();
      n_checks++; if (pc !== 8) begin n_err++; $display("FAIL after_skip act=%0h req=8", pc); end
   endtask

   task automatic test_wrap();
      jump = 1; addr = 13'h1FFE; tick(); jump = 0;
      skip = 1; tick(); skip = 0;
      n_checks++; if (pc !== 0) begin n_err++; $display("FAIL wrap_skip0 act=%0h req=0", pc); end
      jump = 1; addr = 13'h1FFF; tick(); jump = 0;
      skip = 1; tick(); skip = 0;
      n_checks++; if (pc !== 1) begin n_err++; $display("FAIL wrap_skip1 act=%0h req=1", pc); end
      jump = 1; tick(); jump = 0;
      tick();
      n_checks++; if (pc !== 0) begin n_err++; $display("FAIL wrap_inc act=%0h req=0", pc); end
   endtask

   task automatic test_calls();
      do_reset();
      jump = 1; addr = 13'h010; tick(); jump = 0;
      call = 1; addr = 13'h100; tick();
      n_checks++; if (pc !== 13'h100 || depth !== 1) begin n_err++; $display("FAIL call1 pc=%0h d=%0d req 100/1", pc, depth); end
      addr = 13'h200; tick(); call = 0;
      n_checks++; if (pc !== 13'h200 || depth !== 2) begin n_err++; $display("FAIL call2 pc=%0h d=%0d req 200/2", pc, depth); end
      ret = 1; tick();
      n_checks++; if (pc !== 13'h101 || depth !== 1) begin n_err++; $display("FAIL ret1 pc=%0h d=%0d req 101/1", pc, depth); end
      tick(); ret = 0;
      n_checks++; if (pc !== 13'h011 || depth !== 0) begin n_err++; $display("FAIL ret2 pc=%0h d=%0d req 11/0", pc, depth); end
   endtask

   task automatic test_overflow();
      logic [PC_W-1:0] t;
      logic [PC_W-1:0] rets [4];
      rets[0] = 13'h061; rets[1] = 13'h051; rets[2] = 13'h041; rets[3] = 13'h001;
      do_reset();
      call = 1;
      for (int i = 0; i < 5; i++) begin
         t = PC_W'(13'h040 + 13'h010 * i);
         addr = t; tick();
         n_checks++; if (pc !== t || depth !== 3'((i < 4) ? i + 1 : 4) || ovf !== (i == 4)) begin
            n_err++; $display("FAIL ovf_call%0d pc=%0h d=%0d ovf=%b req pc=%0h", i, pc, depth, ovf, t);
         end
      end
      call = 0; ret = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++; if (pc !== rets[i]) begin n_err++; $display("FAIL lifo%0d act=%0h req=%0h", i, pc, rets[i]); end
      end
      tick(); ret = 0;
      n_checks++; if (unf !== 1 || pc !== 13'h002 || depth !== 0) begin
         n_err++; $display("FAIL unf unf=%b pc=%0h d=%0d req 1/2/0", unf, pc, depth);
      end
      n_checks++; if (ovf !== 1) begin n_err++; $display("FAIL ovf_sticky act=%b req=1", ovf); end
   endtask

   task automatic test_priority();
      do_reset();
      jump = 1; addr = PC_W'(13'h020 - (LAT - 1)); tick(); jump = 0;
      gie = 1; mask = 4'b1111; irq = 4'b1010;
      repeat (LAT - 1) tick();
      n_checks++; if (squash !== 1 || pc !== 13'h020) begin n_err++; $display("FAIL prio_squash sq=%b pc=%0h req 1/20", squash, pc); end
      tick();
      n_checks++; if (pc !== 8 || ack !== 4'b0010) begin n_err++; $display("FAIL prio_entry pc=%0h ack=%b req 8/0010", pc, ack); end
      n_checks++; if (in_isr !== 1 || depth !== 1 || squash !== 0) begin n_err++; $display("FAIL prio_state isr=%b d=%0d sq=%b", in_isr, depth, squash); end
      tick();
      n_checks++; if (pc !== 9 || ack !== 0) begin n_err++; $display("FAIL prio_ackpulse pc=%0h ack=%b req 9/0", pc, ack); end
      reti = 1; tick(); reti = 0;
      n_checks++; if (pc !== 13'h020 || in_isr !== 0 || squash !== 1) begin n_err++; $display("FAIL prio_reti pc=%0h isr=%b sq=%b", pc, in_isr, squash); end
      tick();
      n_checks++; if (pc !== 16 || ack !== 4'b1000) begin n_err++; $display("FAIL prio_ch3 pc=%0h ack=%b req 10/1000", pc, ack); end
      reti = 1; tick(); reti = 0;
      n_checks++; if (pc !== 13'h020 || in_isr !== 0 || squash !== 0) begin n_err++; $display("FAIL prio_reti2 pc=%0h isr=%b sq=%b", pc, in_isr, squash); end
   endtask

   task automatic test_halt();
      do_reset();
      gie = 1; mask = 4'b1111;
      jump = 1; addr = 13'h030; tick(); jump = 0;
      halt = 1; tick();
      n_checks++; if (pc !== 13'h030) begin n_err++; $display("FAIL halt_hold act=%0h req=30", pc); end
      irq = 4'b0001;
      repeat (LAT - 1) tick();
      n_checks++; if (pc !== 13'h030 || squash !== 1) begin n_err++; $display("FAIL halt_pend pc=%0h sq=%b", pc, squash); end
      tick(); halt = 0;
      n_checks++; if (pc !== 4 || in_isr !== 1 || ack !== 4'b0001) begin n_err++; $display("FAIL halt_wake pc=%0h isr=%b ack=%b", pc, in_isr, ack); end
      reti = 1; tick(); reti = 0;
      n_checks++; if (pc !== 13'h031 || in_isr !== 0) begin n_err++; $display("FAIL halt_reti pc=%0h isr=%b req 31/0", pc, in_isr); end
   endtask

   task automatic test_mask();
      do_reset();
      gie = 1; mask = 4'b1011; irq = 4'b0100;
      repeat (LAT + 3) tick();
      n_checks++; if (in_isr !== 0 || squash !== 0 || pc !== PC_W'(LAT + 3)) begin
         n_err++; $display("FAIL mask_block isr=%b sq=%b pc=%0h", in_isr, squash, pc);
      end
      mask = 4'b1111; #1;
      n_checks++; if (squash !== 1) begin n_err++; $display("FAIL mask_pend act=%b req=1", squash); end
      tick();
      n_checks++; if (pc !== 12 || ack !== 4'b0100) begin n_err++; $display("FAIL mask_entry pc=%0h ack=%b req c/0100", pc, ack); end
   endtask

   task automatic test_latency();
      int n;
      do_reset();
      gie = 1; mask = 4'b1111; irq = 4'b0010;
      n = 0;
      while (in_isr !== 1 && n < 20) begin
         tick();
         n++;
      end
      n_checks++; if (n != LAT || pc !== 8) begin n_err++; $display("FAIL latency cycles=%0d pc=%0h req %0d/8", n, pc, LAT); end
   endtask

   task automatic test_random();
      int e_pc;
      bit e_ovf, e_unf;
      do_reset();
      mq.delete();
      e_pc = 0; e_ovf = 0; e_unf = 0;
      for (int k = 0; k < 300; k++) begin
         halt = ($urandom_range(0, 9) == 0);
         jump = ($urandom_range(0, 7) == 0);
         call = ($urandom_range(0, 4) == 0);
         ret  = ($urandom_range(0, 6) == 0);
         reti = ($urandom_range(0, 9) == 0);
         skip = ($urandom_range(0, 4) == 0);
         addr = PC_W'($urandom_range(0, MODV - 1));
         if (halt) begin
         end else if (jump) begin
            e_pc = int'(addr);
         end else if (call) begin
            if (mq.size() < SD) mq.push_back((e_pc + 1) % MODV);
            else e_ovf = 1;
            e_pc = int'(addr);
         end else if (ret || reti) begin
            if (mq.size() > 0) e_pc = mq.pop_back();
            else begin e_unf = 1; e_pc = (e_pc + 1) % MODV; end
         end else if (skip) begin
            e_pc = (e_pc + 2) % MODV;
         end else begin
            e_pc = (e_pc + 1) % MODV;
         end
         tick();
         n_checks++; if (pc !== PC_W'(e_pc)) begin n_err++; $display("FAIL rnd_pc[%0d] act=%0h req=%0h", k, pc, e_pc); end
         n_checks++; if (depth !== 3'(mq.size())) begin n_err++; $display("FAIL rnd_depth[%0d] act=%0d req=%0d", k, depth, mq.size()); end
         n_checks++; if ({ovf, unf} !== {e_ovf, e_unf}) begin n_err++; $display("FAIL rnd_flags[%0d] act=%b%b req=%b%b", k, ovf, unf, e_ovf, e_unf); end
      end
      clear_in();
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_wrap();
      test_calls();
      test_overflow();
      test_priority();
      test_halt();
      test_mask();
      test_latency();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/trsq_seq.md
# trsq_seq

Parametrised program sequencer for the TRSQ8 core family. It drives the program-ROM address from decoder control strobes and supports:
- relative skip;
- a hardware call/return stack of configurable depth;
- a multi-channel, maskable, prioritised interrupt front end with per-channel vectors.

It is the PC/stack/IRQ section of the core, split out so that the ALU/W-register datapath only sees one squash strobe.

## Interface
Parameters:
- PC_W, 13, program-counter / ROM address width
- STACK_DEPTH, 4, return-stack entries (≥1)
- IRQ_N, 4, interrupt channels (1..8)
- VEC_BASE, 4, address of channel 0 vector
- VEC_STRIDE, 4, address spacing between channel vectors

Ports:
- clk_ip  in  1  clock; all state changes on rising edge
- reset_n_ip  in  1  asynchronous, active-low reset
- prom_addr_op  out  PC_W  current program address (registered)
- jump_ip  in  1  jump to jump_addr_ip
- call_ip  in  1  push PC+1, jump to jump_addr_ip
- jump_addr_ip  in  PC_W  target for jump/call
- ret_ip  in  1  pop into PC (return from call)
- reti_ip  in  1  pop into PC and clear in_isr_op
- skip_ip  in  1  skip condition true (PC+2)
- halt_ip  in  1  current instruction is halt
- irq_ip  in  IRQ_N  interrupt requests, rising-edge sensitive
- irq_mask_ip  in  IRQ_N  per-channel enable (1 = enabled)
- gie_ip  in  1  global interrupt enable
- irq_ack_op  out  IRQ_N  one-hot, one-cycle pulse on interrupt entry
- squash_op  out  1  combinational; current instruction must not commit datapath writes
- in_isr_op  out  1  servicing an interrupt
- depth_op  out  clog2(STACK_DEPTH+1)  live stack occupancy
- stack_ovf_op  out  1  sticky overflow flag
- stack_unf_op  out  1  sticky underflow flag

## Operation
- Reset: all outputs and state go to 0, asynchronously. This covers prom_addr_op, the stack, the pending bits, in_isr_op and both error flags.
- Pending register: a rising edge on irq_ip[i] sets pend[i]. pend[i] clears only when channel i is acknowledged. Masking does not clear pend[i].
- Eligible: an interrupt is eligible when gie_ip=1, in_isr_op=0 and (pend & irq_mask_ip) is non-zero. The lowest-index channel wins. There is no nesting.
- Per-cycle action, highest priority first:
  1. **Interrupt entry.**
     - Push: prom_addr_op, or prom_addr_op+1 if halt_ip=1 (wake from halt resumes after the halt).
     - Load PC with VEC_BASE + k·VEC_STRIDE.
     - Set in_isr_op, pulse irq_ack_op[k] and clear pend[k].
     - squash_op=1 in the entry cycle; all other control inputs are ignored.
  2. **Halt:** PC holds.
  3. **Jump:** PC ← jump_addr_ip.
  4. **Call:** push PC+1, then PC ← jump_addr_ip.
  5. **Return:** ret_ip or reti_ip pops into PC. reti_ip also clears in_isr_op.
  6. **Skip:** PC ← PC+2.
  7. Otherwise PC ← PC+1.
- If more than one of jump_ip, call_ip, ret_ip and reti_ip is asserted, the first in priority order wins.
- Full stack on push: the push is dropped, stack_ovf_op is set, and the PC is still redirected.
- Empty stack on pop: stack_unf_op is set and PC ← PC+1. For reti_ip, in_isr_op still clears.
- Arithmetic: all PC arithmetic is modulo 2^PC_W, so PC+1 and PC+2 wrap to 0/1.
- Edge coincidence: an irq edge in the same cycle as an ack of the same channel leaves pend set, so the channel is re-serviced later.

## Timing
- Target addresses take effect one cycle after the strobe, i.e. they appear on prom_addr_op at the next rising edge.
- Interrupt latency from an irq_ip edge to the vector on prom_addr_op:
  - 2 cycles without the synchroniser (edge-detect register, then entry);
  - 4 cycles with TRSQ_IRQ_SYNC_EN.
- irq_ack_op is registered and asserted during the first vector-fetch cycle.
- depth_op, stack_ovf_op and stack_unf_op update on the same edge as the push or pop.
- Stack ordering is strictly LIFO. A push and a pop never occur in the same cycle.

## Configuration
- TRSQ_IRQ_SYNC_EN defined: each irq_ip bit passes through a 2-flop synchroniser before edge detection. Use this for asynchronous pins; it adds 2 cycles of latency.
- Not defined: irq_ip must be synchronous to clk_ip and feeds the edge detector directly.

## Structure
- Package trsq_pkg holds:
  - the action enum (ACT_IRQ, ACT_HALT, ACT_JUMP, ACT_CALL, ACT_RET, ACT_SKIP, ACT_INC);
  - the default VEC_BASE and VEC_STRIDE constants;
  - a clog2 helper.
- Sub-module trsq_irq_arb contains the optional synchroniser, edge detector, pending register, mask and priority encoder. Its outputs are eligible, index and ack.
- The stack is a register array plus a pointer inside trsq_seq.

## Test plan
- **Reset/sequencing:** release reset with no strobes → prom_addr_op steps 0,1,2,…; skip_ip at PC=5 → next address 7. With PC_W=4, PC=15 plus skip → 1.
- **Nested calls:** STACK_DEPTH=4; call 0x100 from 0x10, then from 0x100 to 0x200; ret, ret → PC 0x101 then 0x11; depth_op 1,2,1,0.
- **Overflow:** 5 calls with STACK_DEPTH=4 → stack_ovf_op=1 after the 5th, depth_op=4, PC at the 5th target.
- **Underflow:** ret_ip with an empty stack → stack_unf_op=1, PC+1.
- **Priority:**
  - Set-up: irq_ip=4'b1010, mask=4'b1111, gie=1, PC=0x20.
  - Entry: vector 4+1·4=8, irq_ack_op=4'b0010, squash_op=1 in the entry cycle.
  - Channel 3: after reti_ip → PC 0x20, then channel 3 entry at vector 16.
- **Halt wake:** halt at PC=0x30, raise irq_ip[0] → vector 4, stack top 0x31; reti_ip returns to 0x31.
- **Masking:** mask[2]=0 and edge on irq_ip[2] → no entry and pend[2] held; set mask[2]=1 → entry at vector 12. Repeat with TRSQ_IRQ_SYNC_EN and check latency of 4 cycles.
